// File: rtl/iir_coeff_loader.sv
// Byte-stream coefficient loader for the IIR lowpass filter: frames header + MSB/LSB pairs into c_we writes.
// Define IIR_COEFF_CHECKSUM_EN to buffer the frame in a shadow store and commit it only on a good trailing checksum.
module iir_coeff_loader #(
    parameter int         NCOEFF  = 20,
    parameter int         COEFF_W = 16,
    parameter logic [7:0] HDR     = 8'hA5,
    parameter int         TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      c_we,
    output logic [$clog2(NCOEFF)-1:0] c_addr,
    output logic [COEFF_W-1:0]        c_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int            AW     = $clog2(NCOEFF);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] K_LAST = AW'(NCOEFF - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MSB, S_LSB, S_WR, S_CHK, S_COMMIT, S_FIN
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       k_q;
    logic [TW-1:0]       tmo_q;
    logic [7:0]          hi_q;
    logic                in_ready_q;
    logic                c_we_q;
    logic [AW-1:0]       c_addr_q;
    logic [COEFF_W-1:0]  c_in_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                xfer_d;
    logic                tmo_hit_d;
    logic [COEFF_W-1:0]  word_d;

    assign xfer_d    = in_valid && in_ready_q;
    assign tmo_hit_d = (tmo_q == T_LAST) && !xfer_d;
    assign word_d    = {hi_q, in_data};

`ifdef IIR_COEFF_CHECKSUM_EN
    logic [COEFF_W-1:0] shadow_q [NCOEFF];
    logic [7:0]         sum_q;

    always_ff @(posedge clk) begin
        if (state_q == S_LSB && xfer_d) begin
            shadow_q[k_q] <= word_d;
        end
    end
`endif

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            tmo_q      <= '0;
            in_ready_q <= 1'b0;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            c_in_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IIR_COEFF_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            c_we_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (xfer_d && in_data == HDR) begin
                        state_q <= S_MSB;
                        k_q     <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef IIR_COEFF_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_MSB: begin
                    if (xfer_d) begin
                        hi_q    <= in_data;
                        tmo_q   <= '0;
                        state_q <= S_LSB;
`ifdef IIR_COEFF_CHECKSUM_EN
                        sum_q   <= sum_q + in_data;
`endif
                    end else if (tmo_hit_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_LSB: begin
                    if (xfer_d) begin
                        tmo_q <= '0;
`ifdef IIR_COEFF_CHECKSUM_EN
                        sum_q <= sum_q + in_data;
                        if (k_q == K_LAST) begin
                            state_q <= S_CHK;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            state_q <= S_MSB;
                        end
`else
                        c_we_q     <= 1'b1;
                        c_addr_q   <= k_q;
                        c_in_q     <= word_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_WR;
`endif
                    end else if (tmo_hit_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WR: begin
                    if (k_q == K_LAST) begin
                        state_q <= S_FIN;
                    end else begin
                        k_q        <= k_q + 1'b1;
                        tmo_q      <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_MSB;
                    end
                end
`ifdef IIR_COEFF_CHECKSUM_EN
                S_CHK: begin
                    if (xfer_d) begin
                        if (8'(sum_q + in_data) == 8'h00) begin
                            k_q        <= '0;
                            c_we_q     <= 1'b1;
                            c_addr_q   <= '0;
                            c_in_q     <= shadow_q[0];
                            in_ready_q <= 1'b0;
                            state_q    <= S_COMMIT;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else if (tmo_hit_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    if (k_q == K_LAST) begin
                        state_q <= S_FIN;
                    end else begin
                        k_q      <= k_q + 1'b1;
                        c_we_q   <= 1'b1;
                        c_addr_q <= k_q + 1'b1;
                        c_in_q   <= shadow_q[k_q + 1'b1];
                    end
                end
`endif
                S_FIN: begin
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign c_we     = c_we_q;
    assign c_addr   = c_addr_q;
    assign c_in     = c_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Scoreboard bench for iir_coeff_loader: expected writes queued at stimulus time, popped on each c_we.
module tb_iir_coeff_loader;
    localparam int NCOEFF  = 20;
    localparam int TIMEOUT = 1024;
    localparam int AW      = $clog2(NCOEFF);
`ifdef IIR_COEFF_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [15:0]   c_in;
    logic          busy;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_we = 0;
    int n_done = 0;
    int n_err = 0;
    int last_we_cyc = 0;
    int err_cyc = 0;
    int last_byte_cyc = 0;
    int mon_e;
    bit rdy_mon = 1'b0;
    bit fin_nxt = 1'b0;
    int exp_q[$];

    iir_coeff_loader #(.NCOEFF(NCOEFF), .COEFF_W(16), .HDR(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .c_we(c_we), .c_addr(c_addr), .c_in(c_in), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] coef(input int k, input logic [15:0] mask);
        logic [15:0] c;
        if (k == 0) c = 16'h4000;
        else if (k == 1) c = 16'hC123;
        else c = 16'h0100 + 16'(k);
        return c ^ mask;
    endfunction

    function automatic int entry(input int k, input logic [15:0] mask);
        return (k << 16) | int'({16'h0000, coef(k, mask)});
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (c_we) begin
            if (exp_q.size() == 0) begin
                check_val("we_unexpected", 32'(c_we), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("we_addr", 32'(c_addr), 32'((mon_e >> 16) & 31));
                check_val("we_data", 32'(c_in), 32'(mon_e & 32'h0000FFFF));
            end
            n_we++;
            last_we_cyc = cyc;
        end
        if (done) begin
            n_done++;
            check_val("done_lat", 32'(cyc - last_we_cyc), 32'd2);
        end
        if (err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (rdy_mon) check_val("in_ready", 32'(in_ready), 32'(!(c_we || fin_nxt)));
        fin_nxt = c_we && (c_addr == AW'(NCOEFF - 1));
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_val("accept_wait", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_byte_cyc = cyc;
    endtask

    task automatic send_frame(input logic [15:0] mask, input bit gaps, input bit bad_cs);
        logic [15:0] w;
        logic [7:0]  sum;
        logic [7:0]  cs;
        int g0, g1, g2;
        g0 = $urandom_range(1, 12);
        g1 = $urandom_range(13, 26);
        g2 = $urandom_range(27, 40);
        sum = 8'h00;
        if (!bad_cs) for (int k = 0; k < NCOEFF; k++) exp_q.push_back(entry(k, mask));
        send_byte(8'hA5);
        for (int k = 0; k < NCOEFF; k++) begin
            w = coef(k, mask);
            if (gaps && (2*k+1 == g0 || 2*k+1 == g1 || 2*k+1 == g2)) @(negedge clk);
            send_byte(w[15:8]);
            if (gaps && (2*k+2 == g0 || 2*k+2 == g1 || 2*k+2 == g2)) @(negedge clk);
            send_byte(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
        end
        if (CSUM) begin
            cs = 8'h00 - sum;
            if (bad_cs) cs = cs + 8'h01;
            send_byte(cs);
        end
    endtask

    task automatic wait_done(input string tag, input int d0, input int we0);
        for (int t = 0; t < 200 && n_done == d0; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check_val(tag, 32'(n_done - d0), 32'd1);
        check_val("frame_writes", 32'(n_we - we0), 32'(NCOEFF));
        check_val("frame_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("frame_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, d0, e0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_c_we", 32'(c_we), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a frame after 7 bytes.
        if (!CSUM) for (int k = 0; k < 3; k++) exp_q.push_back(entry(k, 16'h0000));
        send_byte(8'hA5);
        for (int k = 0; k < 3; k++) begin
            send_byte(coef(k, 16'h0000) >> 8);
            send_byte(coef(k, 16'h0000) & 16'h00FF);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_in_ready", 32'(in_ready), 32'd0);
        check_val("mid_c_we", 32'(c_we), 32'd0);
        check_val("mid_c_addr", 32'(c_addr), 32'd0);
        check_val("mid_c_in", 32'(c_in), 32'd0);
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_done", 32'(done), 32'd0);
        check_val("mid_err", 32'(err), 32'd0);
        check_val("mid_q_drain", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;

        // Full frame with the reference pattern, back to back.
        we0 = n_we; d0 = n_done;
        send_frame(16'h0000, 1'b0, 1'b0);
        wait_done("frame_done", d0, we0);
        check_val("no_err_after_rst", 32'(n_err), 32'd0);

        // Non-header bytes in IDLE are dropped.
        we0 = n_we;
        send_byte(8'h00);
        check_val("junk00_busy", 32'(busy), 32'd0);
        send_byte(8'h5A);
        check_val("junk5A_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check_val("junkFF_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_val("junk_writes", 32'(n_we - we0), 32'd0);
        we0 = n_we; d0 = n_done;
        send_frame(16'h5A5A, 1'b0, 1'b0);
        wait_done("junk_frame_done", d0, we0);

        // Gaps between bytes, with in_ready tracked every cycle.
        rdy_mon = 1'b1;
        we0 = n_we; d0 = n_done;
        send_frame(16'h0F0F, 1'b1, 1'b0);
        wait_done("gap_frame_done", d0, we0);
        rdy_mon = 1'b0;

        // Inter-byte timeout after header + 5 bytes.
        we0 = n_we; e0 = n_err;
        if (!CSUM) for (int k = 0; k < 2; k++) exp_q.push_back(entry(k, 16'h3333));
        send_byte(8'hA5);
        for (int k = 0; k < 2; k++) begin
            send_byte(coef(k, 16'h3333) >> 8);
            send_byte(coef(k, 16'h3333) & 16'h00FF);
        end
        send_byte(coef(2, 16'h3333) >> 8);
        for (int t = 0; t < TIMEOUT + 50 && n_err == e0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        check_val("tmo_err_count", 32'(n_err - e0), 32'd1);
        check_val("tmo_err_cycle", 32'(err_cyc - last_byte_cyc), 32'(TIMEOUT));
        check_val("tmo_writes", 32'(n_we - we0), CSUM ? 32'd0 : 32'd2);
        check_val("tmo_busy", 32'(busy), 32'd0);
        check_val("tmo_q_empty", 32'(exp_q.size()), 32'd0);
        we0 = n_we; d0 = n_done;
        send_frame(16'hC3C3, 1'b0, 1'b0);
        wait_done("post_tmo_done", d0, we0);

`ifdef IIR_COEFF_CHECKSUM_EN
        // Checksum: good frame commits, corrupted checksum aborts.
        we0 = n_we; d0 = n_done;
        send_frame(16'h1234, 1'b0, 1'b0);
        wait_done("cs_good_done", d0, we0);
        we0 = n_we; d0 = n_done; e0 = n_err;
        send_frame(16'h1234, 1'b0, 1'b1);
        for (int t = 0; t < 50 && n_err == e0; t++) @(negedge clk);
        repeat (30) @(negedge clk);
        check_val("cs_bad_err", 32'(n_err - e0), 32'd1);
        check_val("cs_bad_writes", 32'(n_we - we0), 32'd0);
        check_val("cs_bad_done", 32'(n_done - d0), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
